// File: rtl/cnn_frame_feeder.sv
// rtl/cnn_frame_feeder.sv - packs a 5x5 pixel stream into IMGIN, kicks the CNN core, returns its result
// Optional watchdog on the WAIT state: define CNN_TIMEOUT_EN.
module cnn_frame_feeder #(
    parameter int PIX_W       = 8,
    parameter int IMG_DIM     = 5,
    parameter int RES_W       = 4
`ifdef CNN_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 2048
`endif
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               PIX_VALID,
    input  logic [PIX_W-1:0]                   PIX_DATA,
    output logic                               PIX_READY,
    output logic [IMG_DIM*IMG_DIM*PIX_W-1:0]   IMGIN,
    output logic                               START,
    input  logic                               DONE,
    input  logic [RES_W-1:0]                   OUT,
    output logic                               RES_VALID,
    output logic [RES_W-1:0]                   RES_DATA,
    input  logic                               RES_READY,
    output logic                               TIMEOUT,
    output logic                               BUSY
);
    localparam int NPIX  = IMG_DIM * IMG_DIM;
    localparam int IMG_W = NPIX * PIX_W;
    localparam int CNT_W = $clog2(NPIX);

    typedef enum logic [1:0] {S_LOAD, S_KICK, S_WAIT, S_RESULT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [IMG_W-1:0]   imgin_q, imgin_d;
    logic               start_q, start_d;
    logic               res_valid_q, res_valid_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic               busy_q, busy_d;
    logic               done_q;
    logic               done_evt;

    // Only a fresh rising edge counts, so a DONE left high by the previous frame is ignored.
    assign done_evt = DONE & ~done_q;

`ifdef CNN_TIMEOUT_EN
    logic               timeout_q, timeout_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_LOAD;
            pix_cnt_q   <= '0;
            imgin_q     <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CNN_TIMEOUT_EN
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            imgin_q     <= imgin_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= DONE;
`ifdef CNN_TIMEOUT_EN
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        imgin_d     = imgin_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef CNN_TIMEOUT_EN
        timeout_d   = timeout_q;
        wait_cnt_d  = '0;
`endif
        case (state_q)
            S_LOAD: begin
                if (PIX_VALID) begin
                    for (int k = 0; k < NPIX; k++) begin
                        if (pix_cnt_q == CNT_W'(k))
                            imgin_d[k*PIX_W +: PIX_W] = PIX_DATA;
                    end
                    if (pix_cnt_q == CNT_W'(NPIX-1)) begin
                        pix_cnt_d = '0;
                        state_d   = S_KICK;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: begin
                if (done_evt) begin
                    res_data_d  = OUT;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
`ifdef CNN_TIMEOUT_EN
                    timeout_d   = 1'b0;
                end else if (wait_cnt_q == 16'(TIMEOUT_CYC-1)) begin
                    res_data_d  = '1;
                    res_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 16'd1;
`endif
                end
            end
            S_RESULT: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
`ifdef CNN_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // START and BUSY are registered, so they are decoded from the next state.
        start_d = (state_d == S_KICK);
        busy_d  = !((state_d == S_LOAD) && (pix_cnt_d == '0));
    end

    assign PIX_READY = (state_q == S_LOAD);
    assign IMGIN     = imgin_q;
    assign START     = start_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign BUSY      = busy_q;
`ifdef CNN_TIMEOUT_EN
    assign TIMEOUT   = timeout_q;
`else
    assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// tb/tb_cnn_frame_feeder.sv - randomized self-checking bench for cnn_frame_feeder
module tb_cnn_frame_feeder;
    localparam int NPIX  = 25;
    localparam int IMG_W = 200;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             PIX_VALID;
    logic [7:0]       PIX_DATA;
    logic             PIX_READY;
    logic [IMG_W-1:0] IMGIN;
    logic             START;
    logic             DONE;
    logic [3:0]       OUT;
    logic             RES_VALID;
    logic [3:0]       RES_DATA;
    logic             RES_READY;
    logic             TIMEOUT;
    logic             BUSY;

    always #5 CLK = ~CLK;

    cnn_frame_feeder dut (
        .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
        .PIX_READY(PIX_READY), .IMGIN(IMGIN), .START(START), .DONE(DONE), .OUT(OUT),
        .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_READY(RES_READY),
        .TIMEOUT(TIMEOUT), .BUSY(BUSY)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: phase 0=collecting pixels, 1=kick, 2=waiting for core, 3=result held.
    int         m_phase = 0;
    int         m_cnt   = 0;
    int         m_wcnt  = 0;
    logic [7:0] m_pix [NPIX];
    logic       m_prev  = 1'b0;
    logic       m_rv    = 1'b0;
    logic       m_to    = 1'b0;
    logic [3:0] m_res   = 4'h0;
    logic       m_edge;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_phase = 0; m_cnt = 0; m_wcnt = 0; m_prev = 1'b0;
            m_rv = 1'b0; m_to = 1'b0; m_res = 4'h0;
            for (int k = 0; k < NPIX; k++) m_pix[k] = 8'h00;
        end else begin
            m_edge = DONE && !m_prev;
            m_prev = DONE;
            case (m_phase)
                0: if (PIX_VALID) begin
                    m_pix[m_cnt] = PIX_DATA;
                    m_cnt = (m_cnt + 1) % NPIX;
                    if (m_cnt == 0) m_phase = 1;
                end
                1: begin m_phase = 2; m_wcnt = 0; end
                2: begin
                    if (m_edge) begin
                        m_res = OUT; m_rv = 1'b1; m_to = 1'b0; m_phase = 3;
                    end
`ifdef CNN_TIMEOUT_EN
                    else if (m_wcnt == 2047) begin
                        m_res = 4'hF; m_rv = 1'b1; m_to = 1'b1; m_phase = 3;
                    end
`endif
                    else m_wcnt++;
                end
                default: if (RES_READY) begin
                    m_rv = 1'b0; m_to = 1'b0; m_phase = 0;
                end
            endcase
        end
    end

    logic [IMG_W-1:0] e_img;
    always @(negedge CLK) begin
        for (int k = 0; k < NPIX; k++) e_img[k*8 +: 8] = m_pix[k];
        chk("imgin",     IMGIN,     e_img);
        chk("pix_ready", PIX_READY, m_phase == 0);
        chk("start",     START,     m_phase == 1);
        chk("busy",      BUSY,      !(m_phase == 0 && m_cnt == 0));
        chk("res_valid", RES_VALID, m_rv);
        chk("res_data",  RES_DATA,  m_res);
        chk("timeout",   TIMEOUT,   m_to);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid/data with DONE noise
    task automatic send_frame(input int mode, input int base, output int span);
        int k = 0, cyc = 0, first = 0, last = 0;
        bit tog = 1'b1;
        bit acc;
        while (k < NPIX && cyc < 400) begin
            PIX_VALID = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
            tog = !tog;
            PIX_DATA = (mode == 2) ? 8'($urandom) : 8'(base + k);
            if (mode == 2) DONE = 1'($urandom);
            acc = PIX_VALID && PIX_READY;
            tick();
            if (acc) begin
                if (k == 0) first = cyc;
                last = cyc;
                k++;
            end
            cyc++;
        end
        PIX_VALID = 1'b0;
        chk("frame_accepted", k, NPIX);
        span = last - first + 1;
    endtask

    // rdy_delay < 0: RES_READY raised before the result appears
    task automatic finish_frame(input int done_delay, input logic [3:0] res, input int rdy_delay, input bit noise);
        int n = 0;
        PIX_VALID = noise; PIX_DATA = 8'hEE;
        DONE = 1'b0;
        tick();
        repeat (done_delay) tick();
        if (rdy_delay < 0) RES_READY = 1'b1;
        DONE = 1'b1; OUT = res;
        tick();
        DONE = 1'b0; OUT = 4'($urandom);
        while (!RES_VALID && n < 50) begin tick(); n++; end
        chk("res_valid_seen", RES_VALID, 1'b1);
        chk("res_data_lit",   RES_DATA,  res);
        if (rdy_delay > 0) repeat (rdy_delay) tick();
        chk("hold_pix_ready", PIX_READY, 1'b0);
        chk("hold_res_data",  RES_DATA,  res);
        RES_READY = 1'b1; PIX_VALID = 1'b0;
        tick();
        RES_READY = 1'b0;
        chk("back_to_load", PIX_READY, 1'b1);
        chk("idle_busy",    BUSY,      1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int span;
        nRST = 1'b0; PIX_VALID = 1'b0; PIX_DATA = 8'h00;
        DONE = 1'b0; OUT = 4'h0; RES_READY = 1'b0;
        repeat (3) tick();
        chk("rst_imgin", IMGIN, '0);
        chk("rst_busy",  BUSY,  1'b0);
        chk("rst_rv",    RES_VALID, 1'b0);
        nRST = 1'b1;
        tick();

        // 1: back-to-back pixels 0x00..0x18, DONE with OUT=7
        send_frame(0, 0, span);
        chk("start_latency", START, 1'b1);
        tick();
        chk("start_one_cycle", START, 1'b0);
        chk("imgin_lo", IMGIN[7:0],     8'h00);
        chk("imgin_hi", IMGIN[199:192], 8'h18);
        DONE = 1'b1; OUT = 4'h7;
        tick();
        DONE = 1'b0;
        chk("t1_res_valid", RES_VALID, 1'b1);
        chk("t1_res_data",  RES_DATA,  4'h7);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk("t1_load", PIX_READY, 1'b1);

        // 2: valid every other cycle, pixels offered while busy
        send_frame(1, 8'h40, span);
        chk("toggle_span", span, 49);
        finish_frame(5, 4'h3, 0, 1'b1);
        chk("t2_imgin_lo", IMGIN[7:0],     8'h40);
        chk("t2_imgin_hi", IMGIN[199:192], 8'h58);

        // 3: result consumer stalls 10 cycles
        send_frame(2, 0, span);
        finish_frame(3, 4'hA, 10, 1'b0);

        // 4: DONE stuck high across the kick
        DONE = 1'b1;
        send_frame(0, 8'h10, span);
        repeat (20) tick();
        chk("stuck_done_ignored", RES_VALID, 1'b0);
`ifdef CNN_TIMEOUT_EN
        begin
            int n = 0;
            while (!RES_VALID && n < 2100) begin tick(); n++; end
        end
        chk("wd_res_data", RES_DATA, 4'hF);
        chk("wd_timeout",  TIMEOUT,  1'b1);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk("wd_timeout_clr", TIMEOUT, 1'b0);
        DONE = 1'b0;
`else
        DONE = 1'b0;
        tick();
        DONE = 1'b1; OUT = 4'h5;
        tick();
        chk("redone_valid", RES_VALID, 1'b1);
        chk("redone_data",  RES_DATA,  4'h5);
        DONE = 1'b0;
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
`endif

        // 5: reset after pixel 12 discards the partial frame
        for (int k = 0; k < 13; k++) begin
            PIX_VALID = 1'b1; PIX_DATA = 8'(8'h80 + k);
            tick();
        end
        nRST = 1'b0;
        #1;
        chk("mid_rst_imgin", IMGIN,     '0);
        chk("mid_rst_start", START,     1'b0);
        chk("mid_rst_busy",  BUSY,      1'b0);
        chk("mid_rst_rdata", RES_DATA,  4'h0);
        chk("mid_rst_to",    TIMEOUT,   1'b0);
        PIX_VALID = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        send_frame(0, 8'hC0, span);
        chk("fresh_lo", IMGIN[7:0],     8'hC0);
        chk("fresh_hi", IMGIN[199:192], 8'hD8);
        finish_frame(1, 4'h9, 2, 1'b0);

        // randomized frames, some with RES_READY raised in advance
        for (int f = 0; f < 8; f++) begin
            send_frame(2, 0, span);
            finish_frame($urandom_range(0, 6), 4'($urandom),
                         ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 4),
                         1'($urandom));
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
